// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction-fetch front end.
package fetch_pkg;
   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } state_t;

   localparam int QDEPTH     = 2;
   localparam int INST_BYTES = 4;

   // A fetch is legal when word aligned and inside the instruction memory.
   function automatic logic pc_legal(input logic [63:0] pc, input int unsigned depth);
      return (pc[1:0] == 2'b00) && ((pc >> 2) < 64'(depth));
   endfunction
endpackage

// File: rtl/fetch_queue.sv
// Two-entry in-order FIFO carrying {pc, instruction} pairs toward decode.
module fetch_queue #(
   parameter int W = 96
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_push,
   input  logic         i_pop,
   input  logic         i_flush,
   input  logic [W-1:0] i_data,
   output logic [W-1:0] o_data,
   output logic [1:0]   o_count,
   output logic         o_empty,
   output logic         o_full
);
   import fetch_pkg::*;

   logic [W-1:0] r_mem [QDEPTH];
   logic         r_rd;
   logic         r_wr;
   logic [1:0]   r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_rd     <= 1'b0;
         r_wr     <= 1'b0;
         r_count  <= 2'd0;
      end else if (i_flush) begin
         r_rd    <= 1'b0;
         r_wr    <= 1'b0;
         r_count <= 2'd0;
      end else begin
         if (i_push) begin
            r_mem[r_wr] <= i_data;
            r_wr        <= ~r_wr;
         end
         if (i_pop)
            r_rd <= ~r_rd;
         r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
      end
   end

   assign o_data  = r_mem[r_rd];
   assign o_count = r_count;
   assign o_empty = (r_count == 2'd0);
   assign o_full  = (r_count == 2'(QDEPTH));
endmodule

// File: rtl/inst_mem.sv
// Instruction memory: combinational read by word index, synchronous load port.
module inst_mem #(
   parameter int width  = 32,
   parameter int depth  = 80,
   parameter int adr_in = 64
) (
   input  logic              clk,
   input  logic              write_en,
   input  logic [adr_in-1:0] write_adr,
   input  logic [width-1:0]  write_data,
   input  logic [adr_in-1:0] read_adr,
   output logic [width-1:0]  read_data
);
   localparam int AW = $clog2(depth);

   logic [width-1:0] r_mem [depth];

   always_ff @(posedge clk) begin
      if (write_en && (write_adr < adr_in'(depth)))
         r_mem[write_adr[AW-1:0]] <= write_data;
   end

   // Out-of-range reads return zero rather than aliasing into the array.
   assign read_data = (read_adr < adr_in'(depth)) ? r_mem[read_adr[AW-1:0]] : '0;
endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch front end: PC, memory address generation, redirect and
// fault handling, feeding a two-entry queue toward decode.
module inst_fetch #(
   parameter int                width    = 32,
   parameter int                depth    = 80,
   parameter int                adr_in   = 64,
   parameter logic [adr_in-1:0] reset_pc = '0
) (
   input  logic              clk,
   input  logic              rst,
   output logic [adr_in-1:0] read_adr,
   input  logic [width-1:0]  instruction,
   input  logic              redirect_valid,
   input  logic [adr_in-1:0] redirect_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [width-1:0]  out_inst,
   output logic [adr_in-1:0] out_pc,
   output logic              fault
);
   import fetch_pkg::*;

   localparam int QW = adr_in + width;

   state_t            r_state;
   logic [adr_in-1:0] r_pc;
   logic              r_fault;

   logic          w_pop;
   logic          w_space;
   logic          w_legal;
   logic          w_push;
   logic [QW-1:0] w_q_out;
   logic [1:0]    w_count;
   logic          w_empty;
   logic          w_full;

   assign w_pop   = out_valid && out_ready;
   assign w_space = (w_count < 2'(QDEPTH)) || w_pop;
   assign w_legal = pc_legal(64'(r_pc), depth);
   assign w_push  = !redirect_valid && (r_state == RUN) && w_space && w_legal
                    && (!w_full || w_pop);

   fetch_queue #(.W(QW)) u_queue (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_pop   (w_pop && !redirect_valid),
      .i_flush (redirect_valid),
      .i_data  ({r_pc, instruction}),
      .o_data  (w_q_out),
      .o_count (w_count),
      .o_empty (w_empty),
      .o_full  (w_full)
   );

   // Redirect dominates everything, including leaving HALT.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc    <= reset_pc;
         r_fault <= 1'b0;
         r_state <= RUN;
      end else if (redirect_valid) begin
         r_pc    <= redirect_pc;
         r_fault <= 1'b0;
         r_state <= RUN;
      end else if ((r_state == RUN) && w_space) begin
         if (w_legal) begin
            r_pc <= r_pc + adr_in'(INST_BYTES);
         end else begin
            r_fault <= 1'b1;
            r_state <= HALT;
         end
      end
   end

   assign read_adr  = r_pc >> 2;
   assign out_valid = !w_empty;
   assign out_pc    = w_q_out[QW-1:width];
   assign out_inst  = w_q_out[width-1:0];
   assign fault     = r_fault;
endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch against a queue-based behavioural model.
module tb_inst_fetch;
   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] read_adr;
   logic [31:0] instruction;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_inst;
   logic [63:0] out_pc;
   logic        fault;
   logic        mem_we;
   logic [63:0] mem_wadr;
   logic [31:0] mem_wdata;

   always #5 clk = ~clk;

   inst_fetch #(.width(32), .depth(80), .adr_in(64), .reset_pc(64'd0)) dut (
      .clk            (clk),
      .rst            (rst),
      .read_adr       (read_adr),
      .instruction    (instruction),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_inst       (out_inst),
      .out_pc         (out_pc),
      .fault          (fault)
   );

   inst_mem #(32, 80, 64) u_mem (
      .clk        (clk),
      .write_en   (mem_we),
      .write_adr  (mem_wadr),
      .write_data (mem_wdata),
      .read_adr   (read_adr),
      .read_data  (instruction)
   );

   typedef struct {
      logic [63:0] pc;
      logic [31:0] inst;
   } entry_t;

   logic [31:0] m_mem [80];
   entry_t      m_q [$];
   logic [63:0] m_pc;
   logic        m_fault;
   int          n_chk  = 0;
   int          n_pass = 0;
   int          n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_pc    = 64'd0;
      m_fault = 1'b0;
   endtask

   task automatic check_outputs();
      chk("read_adr", read_adr, m_pc / 4);
      chk("out_valid", 64'(out_valid), 64'(m_q.size() != 0));
      chk("fault", 64'(fault), 64'(m_fault));
      if (m_q.size() != 0) begin
         chk("out_pc", out_pc, m_q[0].pc);
         chk("out_inst", 64'(out_inst), 64'(m_q[0].inst));
      end
   endtask

   // One cycle: check at the falling edge, drive inputs, advance the model.
   task automatic step(input logic rv, input logic [63:0] rpc, input logic rdy);
      int  n_before;
      logic pop;
      check_outputs();
      redirect_valid = rv;
      redirect_pc    = rpc;
      out_ready      = rdy;
      n_before = m_q.size();
      pop = (n_before != 0) && rdy;
      if (rv) begin
         m_q.delete();
         m_pc    = rpc;
         m_fault = 1'b0;
      end else begin
         if (pop) void'(m_q.pop_front());
         if (!m_fault && (n_before < 2 || pop)) begin
            if ((m_pc % 4 == 0) && (m_pc / 4 < 80)) begin
               m_q.push_back('{pc: m_pc, inst: m_mem[m_pc / 4]});
               m_pc = m_pc + 64'd4;
            end else begin
               m_fault = 1'b1;
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic run(input int n, input logic rdy);
      for (int i = 0; i < n; i++) step(1'b0, 64'd0, rdy);
   endtask

   initial begin
      rst            = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 64'd0;
      out_ready      = 1'b0;
      mem_we         = 1'b0;
      mem_wadr       = 64'd0;
      mem_wdata      = 32'd0;
      model_reset();

      for (int a = 0; a < 80; a++) begin
         m_mem[a] = (a < 10) ? 32'(a) : $urandom;
         @(negedge clk);
         mem_we    = 1'b1;
         mem_wadr  = 64'(a);
         mem_wdata = m_mem[a];
      end
      @(negedge clk);
      mem_we = 1'b0;

      chk("rst_read_adr", read_adr, 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_inst", 64'(out_inst), 64'd0);
      chk("rst_out_pc", out_pc, 64'd0);
      chk("rst_fault", 64'(fault), 64'd0);
      rst = 1'b0;

      // stream from reset
      run(12, 1'b1);
      // backpressure then release
      step(1'b1, 64'd0, 1'b1);
      run(5, 1'b0);
      run(6, 1'b1);
      // redirect mid-stream
      step(1'b1, 64'd0, 1'b1);
      run(3, 1'b1);
      step(1'b1, 64'd40, 1'b1);
      run(4, 1'b1);
      // range fault at the last word, then recovery
      step(1'b1, 64'd316, 1'b1);
      run(6, 1'b1);
      step(1'b1, 64'd0, 1'b1);
      run(3, 1'b1);
      // misaligned
      step(1'b1, 64'd6, 1'b1);
      run(3, 1'b1);
      // async reset with a full queue
      step(1'b1, 64'd0, 1'b0);
      run(4, 1'b0);
      check_outputs();
      #2 rst = 1'b1;
      #1;
      chk("arst_out_valid", 64'(out_valid), 64'd0);
      chk("arst_fault", 64'(fault), 64'd0);
      chk("arst_read_adr", read_adr, 64'd0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 400; i++) begin
         logic        rv;
         logic [63:0] rpc;
         int          sel;
         rv  = ($urandom_range(0, 9) == 0);
         sel = $urandom_range(0, 9);
         if (sel < 7)       rpc = 64'(4 * $urandom_range(0, 79));
         else if (sel == 7) rpc = 64'($urandom_range(0, 319));
         else               rpc = 64'(4 * $urandom_range(80, 90));
         step(rv, rpc, $urandom_range(0, 3) != 0);
      end
      check_outputs();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction-fetch front end: the initiator side of the instruction-memory read interface.
- Holds the program counter (PC), drives the word address into inst_mem and captures the returned instruction.
- Buffers fetched {pc, instruction} pairs in a 2-entry queue toward decode, with a valid/ready handshake.
- Supports branch/jump redirect and flags out-of-range or misaligned fetches.

Parameters:
- width, 32, instruction width (matches inst_mem width)
- depth, 80, number of instruction words in inst_mem
- adr_in, 64, PC and read_adr width
- reset_pc, 0, byte address loaded into PC on reset

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- read_adr  output  adr_in  word index to inst_mem; equals pc >> 2
- instruction  input  width  inst_mem read data; combinational from read_adr, same cycle
- redirect_valid  input  1  load new PC this cycle (branch/jump taken)
- redirect_pc  input  adr_in  target byte address
- out_valid  output  1  queue head holds a valid entry
- out_ready  input  1  decode accepts the head entry
- out_inst  output  width  head instruction
- out_pc  output  adr_in  byte PC of the head instruction
- fault  output  1  sticky fetch fault (misaligned or out of range)

Behaviour:
- Reset (asynchronous, rst=1):
  - pc=reset_pc, read_adr=reset_pc>>2
  - queue empty, out_valid=0, out_inst=0, out_pc=0, fault=0
  - state=RUN
- States:
  - RUN: fetching.
  - HALT: fault raised; no fetches issued.
- Definitions:
  - pop = out_valid && out_ready
  - space = (count < 2) || pop
- Fetch, every rising edge in RUN with no redirect and space=1:
  - pc legal (pc[1:0]==0 and (pc>>2) < depth): push {pc, instruction}; pc <= pc+4.
  - pc illegal: no push, pc held, fault<=1, go to HALT.
  - space=0: pc held, no push (stall). read_adr stays stable.
- Latency: instruction at pc is visible on out_* one cycle after pc appears on read_adr (queue empty case).
- Throughput: 1 instruction/cycle while out_ready=1.
- Queue: 2-entry FIFO, in-order.
  - out_inst/out_pc are the head entry, valid only when out_valid=1.
  - Head entry is held stable while out_valid && !out_ready.
  - Pop and push in the same cycle when full is legal; count stays 2.
- Redirect (redirect_valid=1 at an edge) has highest priority over fetch, pop and fault:
  - queue flushed (count=0, out_valid=0 next cycle); any concurrent pop is discarded.
  - pc <= redirect_pc; fault <= 0; state <= RUN.
  - No push that cycle.
  - A redirect to an illegal address faults on the following cycle.
- HALT:
  - Queue continues to drain via out_ready.
  - Only redirect or reset leaves HALT.
  - fault remains 1 until then.
- PC arithmetic: pc+4 is modulo 2^adr_in. Wrap is unreachable in practice because the depth check faults first.
- Reset mid-operation: asynchronous clear of all state regardless of handshake or redirect in progress.
- read_adr is always registered pc>>2; no combinational path from redirect_pc to read_adr.

Decomposition:
- Package fetch_pkg:
  - state enum {RUN, HALT}
  - QDEPTH=2
  - INST_BYTES=4
  - helper function for the legality check (alignment plus range against depth)
- Sub-module fetch_queue:
  - parameterised 2-entry FIFO of {adr_in + width} bits
  - ports: push, pop, flush, data in/out, count/empty/full
  - instantiated once in inst_fetch.
- Bench instantiates inst_mem #(32,80,64) connected to inst_fetch.

Test Plan:
- Reset and stream: memory[a]=a for a=0..9, out_ready=1, release rst → out_pc 0,4,8,…,36 on consecutive cycles with out_inst 0..9; first out_valid one cycle after release.
- Backpressure: out_ready=0 after 2 entries → count=2, read_adr frozen at 2, out_pc=0/out_inst=0 stable. Raise out_ready → 0,1,2,3… with no gap or duplicate.
- Redirect: while streaming at pc=12, assert redirect_valid with redirect_pc=40 → queue flushed, next out_pc=40, out_inst=memory[10], no stale entries (pc 8/12) delivered.
- Range fault: redirect_pc=316 (word 79) → deliver word 79, then pc=320 → fault=1, HALT, out_valid drops after drain. Redirect to 0 → fault=0, fetch resumes.
- Misaligned: redirect_pc=6 → no push, fault=1 next cycle, read_adr held at 1.
- Async reset mid-stream: assert rst between clock edges with count=2 → out_valid=0, fault=0, read_adr=0 immediately, without waiting for a clock edge.
